// File: rtl/ast_mux.sv
// ast_mux: packet-aware round-robin merge of RX_DIR Avalon-ST sinks into one source.
// A packet, once started on a port, owns the output until its eop beat is accepted.
module ast_mux #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int unsigned RX_DIR        = 4,
    parameter int unsigned DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                              clk_i,
    input  logic                              srst_i,

    input  logic [DATA_WIDTH*RX_DIR-1:0]      ast_data_i,
    input  logic [RX_DIR-1:0]                 ast_startofpacket_i,
    input  logic [RX_DIR-1:0]                 ast_endofpacket_i,
    input  logic [RX_DIR-1:0]                 ast_valid_i,
    input  logic [EMPTY_WIDTH*RX_DIR-1:0]     ast_empty_i,
    input  logic [CHANNEL_WIDTH*RX_DIR-1:0]   ast_channel_i,
    output logic [RX_DIR-1:0]                 ast_ready_o,

    output logic [DATA_WIDTH-1:0]             ast_data_o,
    output logic                              ast_startofpacket_o,
    output logic                              ast_endofpacket_o,
    output logic                              ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
    output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
    input  logic                              ast_ready_i,

    output logic [DIR_SEL_WIDTH-1:0]          dir_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DIR_SEL_WIDTH-1:0]   r_grant;
    logic [DIR_SEL_WIDTH-1:0]   w_grant_nxt;
    logic [DIR_SEL_WIDTH-1:0]   r_last_grant;
    logic [DIR_SEL_WIDTH-1:0]   w_last_grant_nxt;

    logic [DIR_SEL_WIDTH-1:0]   w_rr_sel;
    logic                       w_rr_hit;
    logic [DIR_SEL_WIDTH-1:0]   w_sel;
    logic                       w_sel_en;
    logic                       w_out_free;
    logic [RX_DIR-1:0]          w_ready;
    logic                       w_accept;

    logic [DATA_WIDTH-1:0]      w_sel_data;
    logic                       w_sel_sop;
    logic                       w_sel_eop;
    logic [EMPTY_WIDTH-1:0]     w_sel_empty;
    logic [CHANNEL_WIDTH-1:0]   w_sel_channel;

    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_sop;
    logic                       r_eop;
    logic                       r_valid;
    logic [EMPTY_WIDTH-1:0]     r_empty;
    logic [CHANNEL_WIDTH-1:0]   r_channel;
    logic [DIR_SEL_WIDTH-1:0]   r_dir;

    assign w_out_free = !r_valid || ast_ready_i;

    // Round-robin search: first valid port at offset 1..RX_DIR after last_grant.
    // Walking offsets from far to near lets the nearest hit win without a break.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_sel = '0;
        for (int i = int'(RX_DIR); i >= 1; i--) begin
            for (int k = 0; k < int'(RX_DIR); k++) begin
                if ((k == ((int'(r_last_grant) + i) % int'(RX_DIR))) && ast_valid_i[k]) begin
                    w_rr_hit = 1'b1;
                    w_rr_sel = DIR_SEL_WIDTH'(k);
                end
            end
        end
    end

    // Next-state logic: pick the serving port, then track packet boundaries.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_sel            = r_grant;
        w_sel_en         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_sel    = w_rr_sel;
                w_sel_en = w_rr_hit;
            end
            ST_LOCKED: begin
                w_sel    = r_grant;
                w_sel_en = 1'b1;
            end
            default: begin
                w_sel    = r_grant;
                w_sel_en = 1'b0;
            end
        endcase

        if (w_accept) begin
            if (w_sel_eop) begin
                w_state_nxt      = ST_IDLE;
                w_last_grant_nxt = w_sel;
            end else begin
                w_state_nxt = ST_LOCKED;
                w_grant_nxt = w_sel;
            end
        end
    end

    // State and arbitration history registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= DIR_SEL_WIDTH'(RX_DIR - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Beat fields of the currently selected port.
    always_comb begin
        w_sel_data    = '0;
        w_sel_sop     = 1'b0;
        w_sel_eop     = 1'b0;
        w_sel_empty   = '0;
        w_sel_channel = '0;
        for (int k = 0; k < int'(RX_DIR); k++) begin
            if (w_sel == DIR_SEL_WIDTH'(k)) begin
                w_sel_data    = ast_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_sop     = ast_startofpacket_i[k];
                w_sel_eop     = ast_endofpacket_i[k];
                w_sel_empty   = ast_empty_i[k*EMPTY_WIDTH +: EMPTY_WIDTH];
                w_sel_channel = ast_channel_i[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            end
        end
    end

    // One-hot ready towards the selected port, only when the output slot can take a beat.
    always_comb begin
        w_ready = '0;
        for (int k = 0; k < int'(RX_DIR); k++) begin
            w_ready[k] = w_sel_en && w_out_free && !srst_i && (w_sel == DIR_SEL_WIDTH'(k));
        end
    end

    assign w_accept    = |(w_ready & ast_valid_i);
    assign ast_ready_o = w_ready;

    // Output register: load on accept, hold under backpressure, drain otherwise.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_data    <= '0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_valid   <= 1'b0;
            r_empty   <= '0;
            r_channel <= '0;
            r_dir     <= '0;
        end else if (w_accept) begin
            r_data    <= w_sel_data;
            r_sop     <= w_sel_sop;
            r_eop     <= w_sel_eop;
            r_valid   <= 1'b1;
            r_empty   <= w_sel_empty;
            r_channel <= w_sel_channel;
            r_dir     <= w_sel;
        end else if (w_out_free) begin
            r_valid   <= 1'b0;
        end
    end

    assign ast_data_o          = r_data;
    assign ast_startofpacket_o = r_sop;
    assign ast_endofpacket_o   = r_eop;
    assign ast_valid_o         = r_valid;
    assign ast_empty_o         = r_empty;
    assign ast_channel_o       = r_channel;
    assign dir_o               = r_dir;

endmodule

// File: doc/ast_mux.md
AST_MUX -- requirements
Module: ast_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data bus width in bits.
REQ-002 Parameter CHANNEL_WIDTH, default 8, channel field width.
REQ-003 Parameter EMPTY_WIDTH, default $clog2(DATA_WIDTH/8), empty field width.
REQ-004 Parameter RX_DIR, default 4, number of sink ports (1..16).
REQ-005 Parameter DIR_SEL_WIDTH, default (RX_DIR == 1 ? 1 : $clog2(RX_DIR)), port index width.
REQ-006 clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 srst_i  input  1  synchronous active-high reset.
REQ-008 ast_data_i  input  DATA_WIDTH x RX_DIR  per-port sink data.
REQ-009 ast_startofpacket_i  input  1 x RX_DIR  per-port start of packet.
REQ-010 ast_endofpacket_i  input  1 x RX_DIR  per-port end of packet.
REQ-011 ast_valid_i  input  1 x RX_DIR  per-port beat valid.
REQ-012 ast_empty_i  input  EMPTY_WIDTH x RX_DIR  per-port empty bytes, meaningful on eop only.
REQ-013 ast_channel_i  input  CHANNEL_WIDTH x RX_DIR  per-port channel.
REQ-014 ast_ready_o  output  1 x RX_DIR  per-port ready.
REQ-015 ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_valid_o, ast_empty_o, ast_channel_o  output  widths as sink  merged source stream.
REQ-016 ast_ready_i  input  1  source-side ready.
REQ-017 dir_o  output  DIR_SEL_WIDTH  index of the port whose beat currently sits in the output register.

Function
REQ-018 A beat on port k SHALL be accepted exactly in a cycle where ast_valid_i[k] and ast_ready_o[k] are both 1.
REQ-019 out_free = !ast_valid_o || ast_ready_i; at most one ast_ready_o bit SHALL be 1, and only when out_free is 1.
REQ-020 The accepted beat's data, sop, eop, empty and channel SHALL appear on the outputs the next cycle with ast_valid_o=1, dir_o=k (latency 1).
REQ-021 Output registers SHALL hold unchanged while ast_valid_o=1 and ast_ready_i=0.
REQ-022 With out_free=1 and no beat accepted, ast_valid_o SHALL go to 0 next cycle.
REQ-023 State machine with states IDLE and LOCKED; register grant (DIR_SEL_WIDTH) and last_grant.
REQ-024 IDLE: grant is the first port with valid=1 searching last_grant+1, +2, ... modulo RX_DIR (round robin); ready_o[grant]=out_free; no valid input -> all ready_o=0.
REQ-025 IDLE, accepted beat with eop=0 -> LOCKED, grant registered.
REQ-026 IDLE, accepted beat with eop=1 (single-beat packet) -> stay IDLE, last_grant=grant.
REQ-027 LOCKED: only ready_o[grant] may be 1 (=out_free); other ports SHALL be stalled regardless of their valid.
REQ-028 LOCKED, accepted beat with eop=1 -> IDLE, last_grant=grant.
REQ-029 sop is passed through, not checked; the first beat accepted in IDLE starts a packet.
REQ-030 Beats SHALL never be interleaved between ports inside a packet; no beat dropped or duplicated.
REQ-031 Back-to-back: eop accepted in cycle N, next packet's first beat (any port) acceptable in cycle N+1; full throughput with ast_ready_i held 1.
REQ-032 RX_DIR=1: port 0 always granted, dir_o=0.

Reset
REQ-033 With srst_i=1 at a rising edge: ast_valid_o=0, state=IDLE, grant=0, last_grant=RX_DIR-1, dir_o=0; other outputs 0.
REQ-034 ast_ready_o SHALL be all 0 while srst_i=1.
REQ-035 Reset mid-packet SHALL abandon the packet and the output beat; after release arbitration restarts from port 0.

Verification
REQ-036 Single beat: port 2 sends data=64'hA5, sop=eop=1, empty=3, channel=7, ready_i=1 -> next cycle identical fields on output, dir_o=2, valid_o for one cycle.
REQ-037 Round robin: ports 0..3 each hold a 2-beat packet valid from the same cycle, ready_i=1 -> output order 0,0,1,1,2,2,3,3, no gaps.
REQ-038 Lock: port 1 mid 5-beat packet, port 0 raises valid -> ready_o[0]=0 until port 1 eop accepted; port 0's packet follows with zero idle cycles.
REQ-039 Backpressure: ready_i randomized 50%, 1000 random-length (1..32 beats) packets over 4 ports -> per-port data order preserved, no loss/duplication, outputs stable while valid_o=1 and ready_i=0, no X on outputs when valid_o=1.
REQ-040 Reset mid-packet: srst_i pulsed during beat 3 of an 8-beat packet -> valid_o=0 next cycle, ready_o all 0 during reset, port 0 granted first afterwards.
REQ-041 Fairness: port 3 valid continuously with single-beat packets, port 0 valid once -> port 0 served within RX_DIR accepted packets.
